// File: rtl/uart_imem_loader.sv
// UART boot loader: 8N1 receiver feeding a little-endian word assembler that fills an
// instruction memory, then enables a synchronised GPIO hand-off path.
`timescale 1ns/1ps
module uart_imem_loader #(
   parameter int CLK_HZ       = 50000000,
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8,
   parameter int IMEM_DEPTH   = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic                    uart_rx_break,
   output logic                    uart_rx_valid,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data,
   input  logic [3:0]              input_gpio_pins,
   output logic [3:0]              output_gpio_pins,
   output logic                    write_done
);
   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int CNT_W  = $clog2(CYCLES_PER_BIT + 1);
   localparam int BIDX_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
   localparam int ADDR_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_HALF   = CNT_W'(CYCLES_PER_BIT / 2);
   localparam logic [BIDX_W-1:0] BIDX_LAST  = BIDX_W'(PAYLOAD_BITS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(IMEM_DEPTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic                    rxd_meta_r;
   logic                    rxd_sync_r;
   logic [1:0]              state_r;
   logic [CNT_W-1:0]        cycle_cnt_r;
   logic [BIDX_W-1:0]       bit_idx_r;
   logic [PAYLOAD_BITS-1:0] rx_data_r;
   logic                    rx_valid_r;
   logic                    rx_break_r;
   logic [1:0]              byte_cnt_r;
   logic [ADDR_W-1:0]       addr_r;
   logic [31:0]             asm_word_r;
   logic                    write_done_r;
   logic [3:0]              gpio_meta_r;
   logic [3:0]              gpio_sync_r;
   logic [3:0]              gpio_out_r;
   logic [31:0]             imem_r [IMEM_DEPTH];

   logic [31:0]             asm_next_s;
   logic                    word_last_s;
   logic                    word_term_s;
   logic                    word_write_s;

   // Two-flop synchroniser on the serial line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta_r <= 1'b0;
         rxd_sync_r <= 1'b0;
      end else begin
         rxd_meta_r <= uart_rxd;
         rxd_sync_r <= rxd_meta_r;
      end
   end

   // Receive FSM: start validation at mid-bit, then one sample per bit period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cycle_cnt_r <= CNT_W'(0);
         bit_idx_r   <= BIDX_W'(0);
         rx_data_r   <= PAYLOAD_BITS'(0);
         rx_valid_r  <= 1'b0;
         rx_break_r  <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         rx_break_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               cycle_cnt_r <= CNT_W'(0);
               bit_idx_r   <= BIDX_W'(0);
               if (uart_rx_en && !rxd_sync_r) state_r <= ST_START;
               else                           state_r <= ST_IDLE;
            end
            ST_START: begin
               if (cycle_cnt_r == CNT_HALF) begin
                  cycle_cnt_r <= CNT_W'(0);
                  state_r     <= rxd_sync_r ? ST_IDLE : ST_DATA;
               end else begin
                  cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cycle_cnt_r == CNT_LAST) begin
                  cycle_cnt_r <= CNT_W'(0);
                  rx_data_r   <= {rxd_sync_r, rx_data_r[PAYLOAD_BITS-1:1]};
                  if (bit_idx_r == BIDX_LAST) state_r <= ST_STOP;
                  else bit_idx_r <= bit_idx_r + BIDX_W'(1);
               end else begin
                  cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (cycle_cnt_r == CNT_LAST) begin
                  cycle_cnt_r <= CNT_W'(0);
                  state_r     <= ST_IDLE;
                  // A low stop bit is a BREAK only when the whole payload was zero
                  if (rxd_sync_r)                          rx_valid_r <= 1'b1;
                  else if (rx_data_r == PAYLOAD_BITS'(0))  rx_break_r <= 1'b1;
               end else begin
                  cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cycle_cnt_r <= CNT_W'(0);
            end
         endcase
      end
   end

   // Merge the incoming byte into its lane and classify a completed word
   always_comb begin
      asm_next_s = asm_word_r;
      asm_next_s[{byte_cnt_r, 3'b000} +: 8] = rx_data_r[7:0];
      word_last_s  = rx_valid_r && !write_done_r && (byte_cnt_r == 2'd3);
      if (word_last_s && (asm_next_s == 32'hFFFF_FFFF)) begin
         word_term_s  = 1'b1;
         word_write_s = 1'b0;
      end else begin
         word_term_s  = 1'b0;
         word_write_s = word_last_s;
      end
   end

   // Loader bookkeeping: byte lane, write address and the sticky done flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt_r   <= 2'd0;
         addr_r       <= ADDR_W'(0);
         asm_word_r   <= 32'h0000_0000;
         write_done_r <= 1'b0;
      end else if (!write_done_r) begin
         if (rx_valid_r) begin
            asm_word_r <= asm_next_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (word_term_s) begin
               write_done_r <= 1'b1;
            end else if (word_write_s) begin
               addr_r <= addr_r + ADDR_W'(1);
               if (addr_r == ADDR_LAST) write_done_r <= 1'b1;
            end
         end else if (rx_break_r) begin
            byte_cnt_r <= 2'd0;
         end
      end
   end

   // Instruction memory has no reset so contents survive a re-boot
   always_ff @(posedge clk) begin
      if (word_write_s) imem_r[addr_r] <= asm_next_s;
   end

   // GPIO: two-flop synchroniser then an output register gated by write_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_meta_r <= 4'b0000;
         gpio_sync_r <= 4'b0000;
         gpio_out_r  <= 4'b0000;
      end else begin
         gpio_meta_r <= input_gpio_pins;
         gpio_sync_r <= gpio_meta_r;
         gpio_out_r  <= write_done_r ? gpio_sync_r : 4'b0000;
      end
   end

   assign uart_rx_break    = rx_break_r;
   assign uart_rx_valid    = rx_valid_r;
   assign uart_rx_data     = rx_data_r;
   assign output_gpio_pins = gpio_out_r;
   assign write_done       = write_done_r;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomised bench for uart_imem_loader with a byte-stream reference model of the loader.
`timescale 1ns/1ps
module tb_uart_imem_loader;
   localparam int CLK_HZ   = 50000000;
   localparam int BIT_RATE = 3125000;       // 16 clocks per bit keeps the run short
   localparam int DEPTH    = 8;
   localparam int BIT_NS   = 20 * (CLK_HZ / BIT_RATE);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_rxd = 1'b1;
   logic       uart_rx_en = 1'b1;
   logic       uart_rx_break;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;
   logic [3:0] input_gpio_pins = 4'b0000;
   logic [3:0] output_gpio_pins;
   logic       write_done;

   uart_imem_loader #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .IMEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
      .uart_rx_break(uart_rx_break), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
      .input_gpio_pins(input_gpio_pins), .output_gpio_pins(output_gpio_pins), .write_done(write_done)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, valid_cnt = 0, break_cnt = 0, last_valid_cyc = 0, done_cyc = 0;
   logic done_prev = 1'b0;
   logic [3:0] gp_d0 = 4'b0000, gp_d1 = 4'b0000, gp_d2 = 4'b0000;

   // reference model state
   logic [7:0]  byte_q [$];
   int          m_addr = 0;
   bit          m_done = 1'b0;
   logic [31:0] exp_mem [DEPTH];
   bit          exp_wr  [DEPTH];

   // Pulse counters, done-rise timestamp and the expected 3-clock GPIO delay line
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (uart_rx_valid) begin
         valid_cnt      <= valid_cnt + 1;
         last_valid_cyc <= cyc;
      end
      if (uart_rx_break) break_cnt <= break_cnt + 1;
      done_prev <= write_done;
      if (write_done && !done_prev) done_cyc <= cyc;
      gp_d0 <= input_gpio_pins;
      gp_d1 <= gp_d0;
      gp_d2 <= gp_d1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%h expected=0x%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [31:0] w;
      if (!m_done) begin
         byte_q.push_back(b);
         if (byte_q.size() == 4) begin
            w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
            byte_q.delete();
            if (w == 32'hFFFF_FFFF) begin
               m_done = 1'b1;
            end else begin
               exp_mem[m_addr] = w;
               exp_wr[m_addr]  = 1'b1;
               m_addr++;
               if (m_addr == DEPTH) m_done = 1'b1;
            end
         end
      end
   endtask

   task automatic model_reset();
      byte_q.delete();
      m_addr = 0;
      m_done = 1'b0;
   endtask

   // en_mode: 0 receiver disabled, 1 enabled, 2 enable dropped after the start bit
   task automatic send_frame(input logic [7:0] b, input logic stop, input int en_mode);
      int vc0, bc0;
      @(negedge clk);
      uart_rx_en = (en_mode != 0);
      vc0 = valid_cnt;
      bc0 = break_cnt;
      uart_rxd = 1'b0;
      #(BIT_NS);
      if (en_mode == 2) uart_rx_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         #(BIT_NS);
      end
      uart_rxd = stop;
      #60;
      if (en_mode != 0) check_eq("rx_data_at_stop", uart_rx_data, b);
      #(BIT_NS - 60);
      uart_rxd = 1'b1;
      #(2 * BIT_NS);
      check_eq("valid_pulses", valid_cnt - vc0, (en_mode != 0 && stop) ? 1 : 0);
      check_eq("break_pulses", break_cnt - bc0, (en_mode != 0 && !stop && b == 8'h00) ? 1 : 0);
      if (en_mode != 0) begin
         if (stop) model_byte(b);
         else if (b == 8'h00 && !m_done) byte_q.delete();
      end
      check_eq("write_done", write_done, m_done);
      uart_rx_en = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1, 1);
   endtask

   task automatic mem_check(input string tag);
      for (int i = 0; i < DEPTH; i++)
         if (exp_wr[i]) check_eq(tag, dut.imem_r[i], exp_mem[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #2000;
      check_eq("outputs_in_reset",
               {23'd0, uart_rx_break, uart_rx_valid, uart_rx_data, output_gpio_pins, write_done}, 32'd0);
      #2000;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog run did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w, snap;
      int vc0, bc0, width;
      for (int i = 0; i < DEPTH; i++) exp_wr[i] = 1'b0;

      do_reset();
      check_eq("outputs_after_reset",
               {23'd0, uart_rx_break, uart_rx_valid, uart_rx_data, output_gpio_pins, write_done}, 32'd0);
      input_gpio_pins = 4'b0111;
      vc0 = valid_cnt;
      bc0 = break_cnt;
      #100us;
      check_eq("idle_no_valid", valid_cnt - vc0, 0);
      check_eq("idle_no_break", break_cnt - bc0, 0);
      check_eq("gpio_gated_before_done", output_gpio_pins, 4'b0000);

      send_word(32'hFC01_0113);
      send_word(32'h0281_2E23);
      check_eq("imem0", dut.imem_r[0], 32'hFC01_0113);
      check_eq("imem1", dut.imem_r[1], 32'h0281_2E23);
      check_eq("done_after_two_words", write_done, 1'b0);

      // partial word then BREAK, a framing error, a disabled frame, and a mid-frame enable drop
      send_frame(8'hAA, 1'b1, 1);
      send_frame(8'hBB, 1'b1, 1);
      send_frame(8'h00, 1'b0, 1);
      send_frame(8'hA5, 1'b0, 1);
      send_frame(8'h55, 1'b1, 0);
      w = 32'h1234_5678;
      send_frame(w[7:0], 1'b1, 2);
      for (int i = 1; i < 4; i++) send_frame(w[8*i +: 8], 1'b1, 1);
      w = $urandom();
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      send_word(w);
      mem_check("imem_partial_load");
      check_eq("gpio_still_gated", output_gpio_pins, 4'b0000);

      snap = dut.imem_r[m_addr];
      send_word(32'hFFFF_FFFF);
      check_eq("done_after_terminator", write_done, 1'b1);
      check_eq("done_latency_le2", ((done_cyc - last_valid_cyc) >= 1 && (done_cyc - last_valid_cyc) <= 2) ? 1 : 0, 1);
      check_eq("terminator_not_written", dut.imem_r[m_addr], snap);
      check_eq("gpio_after_done", output_gpio_pins, 4'b0111);

      for (int k = 0; k < 2; k++) send_word($urandom());
      mem_check("imem_frozen_after_done");
      check_eq("terminator_slot_frozen", dut.imem_r[m_addr], snap);

      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         input_gpio_pins = 4'($urandom_range(0, 15));
         width = $urandom_range(5, 160);
         for (int j = 0; j < width; j++) begin
            @(negedge clk);
            check_eq("gpio_delay3", output_gpio_pins, gp_d2);
         end
      end

      // re-boot: memory keeps old words; fill to depth with random words
      do_reset();
      check_eq("done_cleared_by_reset", write_done, 1'b0);
      check_eq("gpio_gated_after_reset", output_gpio_pins, 4'b0000);
      for (int k = 0; k < DEPTH; k++) begin
         w = $urandom();
         if (w == 32'hFFFF_FFFF) w = 32'h0000_0001;
         send_word(w);
      end
      check_eq("done_on_full_memory", write_done, 1'b1);
      mem_check("imem_full_load");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
